mimg_issue_arb: RTL and testbench

Round-robin issue arbiter between NUM_REQ decode_mimg instances (one per wave slot) and the single image-memory (texture) unit.
- Captures each decoder's one-cycle-valid mimg_inst_t into a per-requester holding register.
- Back-pressures the decoders through their stall inputs.
- Issues one instruction per cycle over a valid/ready interface.
- Bounds in-flight operations with a credit counter that completion returns replenish.

---
 rtl/mimg_issue_arb_pkg.sv | 15 +
 rtl/mimg_issue_arb_rr_arbiter.sv | 30 +++
 rtl/mimg_issue_arb.sv | 124 ++++++++++++
 tb/tb_mimg_issue_arb.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mimg_issue_arb_pkg.sv
// Shared MIMG issue types and the credit depth agreed with the texture unit.
package mimg_issue_arb_pkg;

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] vaddr;
    logic [7:0] vdata;
    logic [4:0] srsrc;
    logic [3:0] dmask;
  } mimg_inst_t;

  localparam int MIMG_INST_W          = $bits(mimg_inst_t);
  localparam int MIMG_ARB_MAX_CREDITS = 8;

endpackage

// File: rtl/mimg_issue_arb_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    logic found;
    int   j;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/mimg_issue_arb.sv
// Round-robin MIMG issue arbiter with per-wave hold registers and credit flow control.
// Optional credit-starvation counter port enabled by `define MIMG_ARB_STALL_CNT_EN.
module mimg_issue_arb
  import mimg_issue_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MAX_CREDITS = MIMG_ARB_MAX_CREDITS,
  parameter int ID_W        = $clog2(NUM_REQ),
  localparam int CW         = $clog2(MAX_CREDITS + 1),
  localparam int IW         = MIMG_INST_W
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ-1:0][IW-1:0]   req_inst_i,
  output logic [NUM_REQ-1:0]           req_stall_o,
  output logic                         iss_valid_o,
  input  logic                         iss_ready_i,
  output logic [IW-1:0]                iss_inst_o,
  output logic [ID_W-1:0]              iss_req_id_o,
  input  logic                         done_valid_i,
  output logic [CW-1:0]                credits_o,
`ifdef MIMG_ARB_STALL_CNT_EN
  output logic [31:0]                  stall_cnt_o,
`endif
  output logic                         busy_o
);

  logic [NUM_REQ-1:0]         hold_v_q, hold_v_d;
  logic [NUM_REQ-1:0][IW-1:0] hold_q;
  logic                       iss_valid_q;
  logic [IW-1:0]              iss_inst_q;
  logic [ID_W-1:0]            iss_id_q;
  logic [ID_W-1:0]            rr_q;
  logic [CW-1:0]              cr_q, cr_d;

  logic [NUM_REQ-1:0] cap;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic               slot_free;
  logic               can_grant;

  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_rr (
    .req_i (hold_v_q),
    .ptr_i (rr_q),
    .gnt_o (gnt_oh),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  // A stalled decoder re-presents its instruction, so only free slots capture.
  assign cap       = req_valid_i & ~hold_v_q;
  assign slot_free = !iss_valid_q || iss_ready_i;
  assign can_grant = slot_free && (cr_q != '0) && gnt_any;
  assign hold_v_d  = (hold_v_q & ~(can_grant ? gnt_oh : '0)) | cap;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hold_v_q <= '0;
    end else begin
      hold_v_q <= hold_v_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cap[i]) hold_q[i] <= req_inst_i[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      iss_valid_q <= 1'b0;
      iss_inst_q  <= '0;
      iss_id_q    <= '0;
      rr_q        <= '0;
    end else if (can_grant) begin
      iss_valid_q <= 1'b1;
      iss_inst_q  <= hold_q[gnt_idx];
      iss_id_q    <= gnt_idx;
      rr_q        <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (slot_free) begin
      iss_valid_q <= 1'b0;
    end
  end

  // Credits are taken at grant; a return that coincides with a grant nets out.
  always_comb begin
    cr_d = cr_q;
    unique case ({can_grant, done_valid_i})
      2'b10:   cr_d = cr_q - 1'b1;
      2'b01:   cr_d = (cr_q == CW'(MAX_CREDITS)) ? cr_q : cr_q + 1'b1;
      default: cr_d = cr_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cr_q <= CW'(MAX_CREDITS);
    else         cr_q <= cr_d;
  end

`ifdef MIMG_ARB_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_cnt_q <= '0;
    end else if (gnt_any && (cr_q == '0) && slot_free) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

  assign req_stall_o  = hold_v_q;
  assign iss_valid_o  = iss_valid_q;
  assign iss_inst_o   = iss_inst_q;
  assign iss_req_id_o = iss_id_q;
  assign credits_o    = cr_q;
  assign busy_o       = (|hold_v_q) || iss_valid_q || (cr_q != CW'(MAX_CREDITS));

endmodule

// File: tb/tb_mimg_issue_arb.sv
// Directed and randomized checks of mimg_issue_arb against a behavioural model.
module tb_mimg_issue_arb;
  import mimg_issue_arb_pkg::*;

  localparam int N    = 4;
  localparam int MAXC = 8;
  localparam int W    = MIMG_INST_W;
  localparam int IDW  = 2;
  localparam int CW   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic [N-1:0]         req_valid;
  logic [N-1:0][W-1:0]  req_inst;
  logic [N-1:0]         req_stall;
  logic                 iss_valid;
  logic                 iss_ready;
  logic [W-1:0]         iss_inst;
  logic [IDW-1:0]       iss_req_id;
  logic                 done_valid;
  logic [CW-1:0]        credits;
  logic                 busy;
`ifdef MIMG_ARB_STALL_CNT_EN
  logic [31:0]          stall_cnt;
  int unsigned          m_sc;
`endif

  mimg_issue_arb #(.NUM_REQ(N), .MAX_CREDITS(MAXC)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .req_valid_i  (req_valid),
    .req_inst_i   (req_inst),
    .req_stall_o  (req_stall),
    .iss_valid_o  (iss_valid),
    .iss_ready_i  (iss_ready),
    .iss_inst_o   (iss_inst),
    .iss_req_id_o (iss_req_id),
    .done_valid_i (done_valid),
    .credits_o    (credits),
`ifdef MIMG_ARB_STALL_CNT_EN
    .stall_cnt_o  (stall_cnt),
`endif
    .busy_o       (busy)
  );

  // Reference state: what each wave holds, what sits on the issue port, credits left.
  bit         m_hv [N];
  logic [W-1:0] m_hold [N];
  bit         m_iv;
  logic [W-1:0] m_inst;
  int         m_id, m_rr, m_cr;
  int         n_pass = 0, n_tot = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_step();
    bit sf;
    int g;
    bit nhv [N];
    if (reset) begin
      for (int i = 0; i < N; i++) m_hv[i] = 0;
      m_iv = 0; m_inst = '0; m_id = 0; m_rr = 0; m_cr = MAXC;
`ifdef MIMG_ARB_STALL_CNT_EN
      m_sc = 0;
`endif
    end else begin
      bit anyh;
      sf = !m_iv || iss_ready;
      g = -1;
      anyh = 0;
      for (int i = 0; i < N; i++) anyh |= m_hv[i];
      if (sf && m_cr > 0)
        for (int k = 0; k < N; k++)
          if (g < 0 && m_hv[(m_rr + k) % N]) g = (m_rr + k) % N;
`ifdef MIMG_ARB_STALL_CNT_EN
      if (anyh && m_cr == 0 && sf) m_sc++;
`endif
      for (int i = 0; i < N; i++) begin
        nhv[i] = m_hv[i];
        if (req_valid[i] && !m_hv[i]) begin
          nhv[i] = 1;
          m_hold[i] = req_inst[i];
        end
      end
      if (g >= 0) begin
        m_inst = m_hold[g]; m_id = g; m_iv = 1;
        nhv[g] = 0; m_rr = (g + 1) % N; m_cr--;
      end else if (sf) begin
        m_iv = 0;
      end
      if (done_valid && m_cr < MAXC) m_cr++;
      for (int i = 0; i < N; i++) m_hv[i] = nhv[i];
    end
  endtask

  task automatic check_all();
    logic [N-1:0] hv;
    bit anyh;
    anyh = 0;
    for (int i = 0; i < N; i++) begin hv[i] = m_hv[i]; anyh |= m_hv[i]; end
    chk("req_stall", 64'(req_stall), 64'(hv));
    chk("iss_valid", 64'(iss_valid), 64'(m_iv));
    chk("iss_inst", 64'(iss_inst), 64'(m_inst));
    chk("iss_req_id", 64'(iss_req_id), 64'(m_id));
    chk("credits", 64'(credits), 64'(m_cr));
    chk("busy", 64'(busy), 64'(anyh || m_iv || m_cr != MAXC));
`ifdef MIMG_ARB_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_sc));
`endif
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic rand_insts();
    for (int i = 0; i < N; i++) req_inst[i] = W'({$urandom(), $urandom()});
  endtask

  task automatic do_reset();
    reset = 1; req_valid = '0; done_valid = 0;
    step();
    reset = 0;
  endtask

  initial begin
    int cnt;
    logic [W-1:0] saved;
    reset = 1; req_valid = '0; req_inst = '0; iss_ready = 1; done_valid = 0;
    @(negedge clk);

    // T1: reset state, then a single request from wave 2
    step();
    chk("rst_credits", 64'(credits), 64'(MAXC));
    chk("rst_iss_valid", 64'(iss_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset = 0;
    req_valid = 4'b0100; req_inst[2] = '0;
    step();
    chk("t1_stall", 64'(req_stall), 64'h4);
    req_valid = '0;
    step();
    chk("t1_iss_valid", 64'(iss_valid), 64'd1);
    chk("t1_iss_id", 64'(iss_req_id), 64'd2);
    chk("t1_credits", 64'(credits), 64'd7);

    // T2: round-robin order from ptr 0, then from ptr 1
    do_reset();
    done_valid = 1; iss_ready = 1;
    rand_insts(); req_valid = 4'b1111;
    step();
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t2_order_a", 64'(iss_req_id), 64'(k));
    end
    step();
    req_valid = 4'b0001; rand_insts();
    step();
    req_valid = '0;
    step();
    chk("t2_single0", 64'(iss_req_id), 64'd0);
    rand_insts(); req_valid = 4'b1111;
    step();
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t2_order_b", 64'(iss_req_id), 64'((k + 1) % 4));
    end
    done_valid = 0;

    // T3: credit exhaustion and one-for-one replenish
    do_reset();
    iss_ready = 1; req_valid = 4'b1111; cnt = 0;
    for (int k = 0; k < 20; k++) begin
      rand_insts();
      step();
      if (iss_valid) cnt++;
    end
    chk("t3_issues", 64'(cnt), 64'd8);
    chk("t3_credits0", 64'(credits), 64'd0);
    chk("t3_all_stall", 64'(req_stall), 64'hf);
    done_valid = 1; cnt = 0;
    step();
    done_valid = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (iss_valid) cnt++;
    end
    chk("t3_one_more", 64'(cnt), 64'd1);

    // T4: back-pressure keeps the issue port frozen
    do_reset();
    iss_ready = 0; rand_insts(); req_valid = 4'b1111;
    step();
    req_valid = '0;
    step();
    saved = iss_inst;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t4_inst_stable", 64'(iss_inst), 64'(saved));
      chk("t4_id_stable", 64'(iss_req_id), 64'd0);
      chk("t4_credits", 64'(credits), 64'd7);
      chk("t4_holds", 64'(req_stall), 64'he);
    end
    iss_ready = 1;
    step();
    chk("t4_next_id", 64'(iss_req_id), 64'd1);
    chk("t4_next_cr", 64'(credits), 64'd6);

    // T5: grant+done same cycle, done at full credits
    do_reset();
    iss_ready = 1; rand_insts(); req_valid = 4'b0100;
    step();
    req_valid = '0;
    step();
    req_valid = 4'b0010;
    step();
    req_valid = '0; done_valid = 1;
    step();
    chk("t5_net_zero", 64'(credits), 64'd7);
    chk("t5_granted", 64'(iss_req_id), 64'd1);
    step();
    chk("t5_refill", 64'(credits), 64'd8);
    step();
    chk("t5_saturate", 64'(credits), 64'd8);
    done_valid = 0;

    // T6: reset mid-operation discards holds and pending issue
    do_reset();
    iss_ready = 0; rand_insts(); req_valid = 4'b0111;
    step();
    req_valid = '0;
    step();
    reset = 1;
    step();
    chk("t6_iss_valid", 64'(iss_valid), 64'd0);
    chk("t6_stall", 64'(req_stall), 64'd0);
    chk("t6_credits", 64'(credits), 64'd8);
    chk("t6_id", 64'(iss_req_id), 64'd0);
    chk("t6_inst", 64'(iss_inst), 64'd0);
    reset = 0; iss_ready = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t6_no_issue", 64'(iss_valid), 64'd0);
    end

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      rand_insts();
      req_valid  = N'($urandom());
      iss_ready  = ($urandom_range(3) != 0);
      done_valid = ($urandom_range(9) < 3);
      reset      = ($urandom_range(99) < 2);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
